// File: rtl/packet_scheduler_if.sv
// Channel-to-framer bundle for packet_scheduler: sample strobes/data in, one granted frame out.
// master = channel/framer side, slave = scheduler side.
interface packet_scheduler_if #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned CH_BITS    = 2,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                       i_en;
  logic [N_CH-1:0]            i_strobe;
  logic [N_CH*DATA_WIDTH-1:0] i_data;
  logic [7:0]                 i_id_base;
  logic                       i_framer_busy;
  logic                       i_clr_overrun;
  logic                       o_trigger;
  logic [7:0]                 o_id;
  logic [DATA_WIDTH-1:0]      o_data;
  logic [CH_BITS-1:0]         o_grant;
  logic                       o_busy;
  logic [N_CH-1:0]            o_overrun;

  modport master (
    output i_en, i_strobe, i_data, i_id_base, i_framer_busy, i_clr_overrun,
    input  o_trigger, o_id, o_data, o_grant, o_busy, o_overrun
  );

  modport slave (
    input  i_en, i_strobe, i_data, i_id_base, i_framer_busy, i_clr_overrun,
    output o_trigger, o_id, o_data, o_grant, o_busy, o_overrun
  );
endinterface

// File: rtl/packet_scheduler.sv
// Round-robin scheduler sharing one framer between N_CH decimated channels.
// Latches per-channel samples, grants one channel per frame and paces frames with a gap.
module packet_scheduler #(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned CH_BITS       = 2,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned START_TIMEOUT = 4,
  parameter int unsigned GAP_CYCLES    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  packet_scheduler_if.slave bus
);

  localparam int unsigned CNT_MAX = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam int unsigned HOLD_W  = N_CH * DATA_WIDTH;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] LOAD       = 3'd1;
  localparam logic [2:0] TRIG       = 3'd2;
  localparam logic [2:0] WAIT_START = 3'd3;
  localparam logic [2:0] WAIT_DONE  = 3'd4;
  localparam logic [2:0] GAP        = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CH_BITS-1:0]    g_q, g_d, last_q, last_d;
  logic [CH_BITS-1:0]    pick, idx;
  logic                  pick_found;
  logic [N_CH-1:0]       pend_q, pend_d, ovr_q, ovr_d, cap, load_clr;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [DATA_WIDTH-1:0] hold_arr [N_CH];
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [7:0]            id_q, id_d;
  logic [CH_BITS-1:0]    grant_q, grant_d;
  logic                  trig_q, busy_q;

  assign cap = {N_CH{bus.i_en}} & bus.i_strobe;

  // Per-channel holding registers: a strobe always overwrites (newest sample wins).
  for (genvar k = 0; k < N_CH; k++) begin : g_hold
    assign hold_d[k*DATA_WIDTH +: DATA_WIDTH] = cap[k] ? bus.i_data[k*DATA_WIDTH +: DATA_WIDTH]
                                                       : hold_q[k*DATA_WIDTH +: DATA_WIDTH];
    assign hold_arr[k] = hold_q[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // First pending channel after the last grant, wrapping modulo N_CH.
  always_comb begin
    pick_found = 1'b0;
    pick       = last_q;
    idx        = '0;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      idx = CH_BITS'((32'(last_q) + i) % N_CH);
      if (!pick_found && pend_q[idx]) begin
        pick_found = 1'b1;
        pick       = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    g_d      = g_q;
    last_d   = last_q;
    data_d   = data_q;
    id_d     = id_q;
    grant_d  = grant_q;
    load_clr = '0;
    case (state_q)
      IDLE: begin
        if (bus.i_en && pick_found) begin
          g_d     = pick;
          state_d = LOAD;
        end
      end
      LOAD: begin
        data_d   = hold_arr[g_q];
        id_d     = bus.i_id_base | 8'(g_q);
        grant_d  = g_q;
        last_d   = g_q;
        load_clr = N_CH'(1) << g_q;
        state_d  = TRIG;
      end
      TRIG: begin
        cnt_d   = '0;
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (bus.i_framer_busy) begin
          state_d = WAIT_DONE;
        end else if (32'(cnt_q) + 32'd1 >= START_TIMEOUT) begin
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!bus.i_framer_busy) begin
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (32'(cnt_q) + 32'd1 >= GAP_CYCLES) state_d = IDLE;
        else                                  cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    // A strobe landing on the LOAD cycle of its own channel re-arms it without overrun.
    pend_d = (pend_q & ~load_clr) | cap;
    ovr_d  = (bus.i_clr_overrun ? '0 : ovr_q) | (cap & pend_q & ~load_clr);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      g_q     <= '0;
      last_q  <= CH_BITS'(N_CH - 1);
      pend_q  <= '0;
      ovr_q   <= '0;
      hold_q  <= '0;
      data_q  <= '0;
      id_q    <= '0;
      grant_q <= '0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      g_q     <= g_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      id_q    <= id_d;
      grant_q <= grant_d;
      trig_q  <= (state_d == TRIG);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.o_trigger = trig_q;
  assign bus.o_id      = id_q;
  assign bus.o_data    = data_q;
  assign bus.o_grant   = grant_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_overrun = ovr_q;

endmodule

// File: tb/tb_packet_scheduler.sv
// Scoreboard bench for packet_scheduler: directed frames queued as expectations,
// a monitor pops one per o_trigger pulse, and a simple framer model answers triggers.
module tb_packet_scheduler;

  typedef struct packed {
    logic [1:0]  g;
    logic [7:0]  id;
    logic [31:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   trig_cnt = 0;
  int   last_trig = 0;
  int   prev_trig = 0;
  logic trig_prev = 1'b0;
  int   busy_len = 10;
  exp_t sb [$];

  packet_scheduler_if #(.N_CH(4), .CH_BITS(2), .DATA_WIDTH(32)) bus ();

  packet_scheduler #(
    .N_CH(4), .CH_BITS(2), .DATA_WIDTH(32), .START_TIMEOUT(4), .GAP_CYCLES(16)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name, input int budget);
    n_vec++;
    n_err++;
    $display("FAIL %s: condition not reached within %0d cycles", name, budget);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic post(input logic [3:0] mask, input logic clr);
    bus.i_strobe      = mask;
    bus.i_clr_overrun = clr;
    tick();
    bus.i_strobe      = '0;
    bus.i_clr_overrun = 1'b0;
  endtask

  task automatic set_data(input int ch, input logic [31:0] d);
    bus.i_data[ch*32 +: 32] = d;
  endtask

  task automatic expect_frame(input logic [1:0] g, input logic [7:0] id, input logic [31:0] d);
    exp_t e;
    e.g  = g;
    e.id = id;
    e.d  = d;
    sb.push_back(e);
  endtask

  task automatic wait_busy(input logic level, input int budget, input string name);
    int n = 0;
    while (bus.i_framer_busy !== level && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus.i_framer_busy !== level) timeout(name, budget);
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    @(negedge clk);
    while (!(sb.size() == 0 && bus.o_busy === 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(sb.size() == 0 && bus.o_busy === 1'b0)) timeout(name, budget);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_trigger"}, 64'(bus.o_trigger), 64'd0);
    check({tag, "_id"},      64'(bus.o_id),      64'd0);
    check({tag, "_data"},    64'(bus.o_data),    64'd0);
    check({tag, "_grant"},   64'(bus.o_grant),   64'd0);
    check({tag, "_busy"},    64'(bus.o_busy),    64'd0);
    check({tag, "_overrun"}, 64'(bus.o_overrun), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // Monitor: every trigger pulse must match the oldest expected frame.
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.o_trigger === 1'b1) begin
      trig_cnt++;
      prev_trig = last_trig;
      last_trig = cyc;
      check("trigger_single_cycle", 64'(trig_prev), 64'd0);
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_trigger: grant %0d id 0x%0h, expected no frame", bus.o_grant, bus.o_id);
      end else begin
        e = sb.pop_front();
        check("frame_grant", 64'(bus.o_grant), 64'(e.g));
        check("frame_id",    64'(bus.o_id),    64'(e.id));
        check("frame_data",  64'(bus.o_data),  64'(e.d));
      end
    end
    trig_prev = bus.o_trigger;
  end

  // Framer model: busy rises the cycle after a trigger and lasts busy_len cycles (0 = never).
  always begin : framer
    @(negedge clk);
    if (bus.o_trigger === 1'b1 && busy_len > 0) begin
      @(posedge clk);
      #1 bus.i_framer_busy = 1'b1;
      repeat (busy_len) @(posedge clk);
      #1 bus.i_framer_busy = 1'b0;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int c0;
    bus.i_en          = 1'b1;
    bus.i_strobe      = '0;
    bus.i_data        = '0;
    bus.i_id_base     = 8'h80;
    bus.i_framer_busy = 1'b0;
    bus.i_clr_overrun = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    tick();

    // Single channel: ch2 triggers two edges after its strobe edge.
    set_data(2, 32'hDEADBEEF);
    expect_frame(2'd2, 8'h82, 32'hDEADBEEF);
    post(4'b0100, 1'b0);
    @(negedge clk); check("lat_idle", 64'(bus.o_trigger), 64'd0);
    @(negedge clk); check("lat_load", 64'(bus.o_trigger), 64'd0);
    @(negedge clk); check("lat_trig", 64'(bus.o_trigger), 64'd1);
    wait_busy(1'b1, 10, "framer_rise");
    wait_busy(1'b0, 20, "framer_fall");
    // One cycle to see busy fall, then 16 GAP cycles before IDLE.
    repeat (16) @(negedge clk);
    check("gap_last_cycle_busy", 64'(bus.o_busy), 64'd1);
    @(negedge clk);
    check("gap_done_idle", 64'(bus.o_busy), 64'd0);
    check("hold_data_after_frame", 64'(bus.o_data), 64'hDEADBEEF);
    check("hold_grant_after_frame", 64'(bus.o_grant), 64'd2);

    // Round-robin from a fresh reset.
    do_reset();
    busy_len = 3;
    for (int k = 0; k < 4; k++) begin
      set_data(k, 32'(k));
      expect_frame(2'(k), 8'h80 | 8'(k), 32'(k));
    end
    post(4'hF, 1'b0);
    wait_done(400, "rr_first_pass");
    for (int k = 0; k < 4; k++) begin
      set_data(k, 32'h10 + 32'(k));
      expect_frame(2'(k), 8'h80 | 8'(k), 32'h10 + 32'(k));
    end
    post(4'hF, 1'b0);
    wait_done(400, "rr_second_pass");
    check("rr_no_overrun", 64'(bus.o_overrun), 64'd0);

    // Overrun on ch1 while ch0 is in WAIT_DONE, clear, then clear+overrun together.
    busy_len = 30;
    set_data(0, 32'hA0);
    expect_frame(2'd0, 8'h80, 32'hA0);
    post(4'b0001, 1'b0);
    wait_busy(1'b1, 10, "ovr_framer_rise");
    set_data(1, 32'h11);
    post(4'b0010, 1'b0);
    set_data(1, 32'h22);
    post(4'b0010, 1'b0);
    @(negedge clk);
    check("overrun_set", 64'(bus.o_overrun), 64'b0010);
    bus.i_clr_overrun = 1'b1;
    tick();
    bus.i_clr_overrun = 1'b0;
    @(negedge clk);
    check("overrun_cleared", 64'(bus.o_overrun), 64'd0);
    set_data(1, 32'h33);
    post(4'b0010, 1'b1);
    @(negedge clk);
    check("overrun_set_wins_clear", 64'(bus.o_overrun), 64'b0010);
    expect_frame(2'd1, 8'h81, 32'h33);
    wait_done(400, "ovr_frames");
    bus.i_clr_overrun = 1'b1;
    tick();
    bus.i_clr_overrun = 1'b0;
    @(negedge clk);
    check("overrun_final_clear", 64'(bus.o_overrun), 64'd0);

    // Start timeout: framer never answers; TRIG-to-TRIG = 1 TRIG + 4 WAIT_START + 16 GAP + IDLE + LOAD.
    busy_len = 0;
    bus.i_id_base = 8'hF0;
    set_data(2, 32'h2222);
    set_data(3, 32'h3333);
    expect_frame(2'd2, 8'hF2, 32'h2222);
    expect_frame(2'd3, 8'hF3, 32'h3333);
    post(4'b1100, 1'b0);
    wait_done(400, "timeout_frames");
    check("start_timeout_spacing", 64'(last_trig - prev_trig), 64'd23);

    // Enable low: strobes dropped, nothing triggers afterwards.
    bus.i_id_base = 8'h80;
    busy_len = 10;
    bus.i_en = 1'b0;
    set_data(0, 32'h5555);
    post(4'b0001, 1'b0);
    repeat (3) tick();
    bus.i_en = 1'b1;
    c0 = trig_cnt;
    repeat (20) @(negedge clk);
    check("en_low_strobe_dropped", 64'(trig_cnt), 64'(c0));

    // Enable drop in WAIT_DONE: ch0 finishes, ch1 stays pending until re-enabled.
    set_data(0, 32'h50);
    set_data(1, 32'h51);
    expect_frame(2'd0, 8'h80, 32'h50);
    post(4'b0011, 1'b0);
    wait_busy(1'b1, 10, "en_framer_rise");
    bus.i_en = 1'b0;
    wait_done(100, "en_drop_frame");
    c0 = trig_cnt;
    repeat (30) @(negedge clk);
    check("en_drop_no_new_grant", 64'(trig_cnt), 64'(c0));
    check("en_drop_busy_low", 64'(bus.o_busy), 64'd0);
    expect_frame(2'd1, 8'h81, 32'h51);
    bus.i_en = 1'b1;
    wait_done(100, "en_restore_frame");

    // Reset in WAIT_DONE clears outputs immediately; ch0 wins first afterwards.
    busy_len = 30;
    set_data(2, 32'h6666);
    expect_frame(2'd2, 8'h82, 32'h6666);
    post(4'b0100, 1'b0);
    wait_busy(1'b1, 10, "rst_framer_rise");
    rst = 1'b1;
    #1;
    check_zero_outputs("async_reset");
    wait_busy(1'b0, 60, "rst_framer_fall");
    tick();
    rst = 1'b0;
    busy_len = 3;
    set_data(0, 32'h0C0C);
    set_data(3, 32'h3030);
    expect_frame(2'd0, 8'h80, 32'h0C0C);
    expect_frame(2'd3, 8'h83, 32'h3030);
    post(4'b1001, 1'b0);
    wait_done(200, "post_reset_frames");

    // Collision: ch0 strobed on its own LOAD cycle sends old data, then new data.
    busy_len = 2;
    bus.i_id_base = 8'h40;
    set_data(0, 32'h111);
    expect_frame(2'd0, 8'h40, 32'h111);
    expect_frame(2'd0, 8'h40, 32'h222);
    bus.i_strobe = 4'b0001;
    tick();
    bus.i_strobe = 4'b0000;
    tick();
    set_data(0, 32'h222);
    bus.i_strobe = 4'b0001;
    tick();
    bus.i_strobe = 4'b0000;
    wait_done(200, "collision_frames");
    check("collision_no_overrun", 64'(bus.o_overrun), 64'd0);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
